// File: rtl/uart_txfifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_txfifo : CPU-fed byte FIFO drained into a memory-mapped uart by a      |
// |               poll/send master. Optional flush: UART_TXFIFO_FLUSH_EN.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module uart_txfifo #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] UART_BASE = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iob_val,
  output logic        iob_rdy,
  input  logic [31:0] iob_adr,
  input  logic [3:0]  iob_wen,
  input  logic [31:0] iob_wdat,
  output logic [31:0] iob_rdat,
  output logic        m_val,
  input  logic        m_rdy,
  output logic [31:0] m_adr,
  output logic [3:0]  m_wen,
  output logic [31:0] m_wdat,
  input  logic [31:0] m_rdat
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [8:0]  FULL_CNT = 9'(DEPTH);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_POLL = 2'd2,
    S_SEND = 2'd3
  } state_t;

  logic          r_iob_rdy;
  logic          r_drain_en;
  logic          r_ovf;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [8:0]    r_count;
  logic [7:0]    r_mem [DEPTH];

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_m_val;
  logic          w_m_val_nxt;
  logic [31:0]   r_m_adr;
  logic [31:0]   w_m_adr_nxt;
  logic [3:0]    r_m_wen;
  logic [3:0]    w_m_wen_nxt;
  logic [31:0]   r_m_wdat;
  logic [31:0]   w_m_wdat_nxt;

  logic          w_cpu_wr;
  logic          w_push;
  logic          w_push_ok;
  logic          w_pop_req;
  logic          w_pop;
  logic          w_pop_en;
  logic          w_flush;
  logic          w_full;
  logic          w_empty;
  logic          w_done;
  logic          w_unused;

  assign w_cpu_wr  = iob_val & (|iob_wen) & ~r_iob_rdy;
  assign w_push    = w_cpu_wr & (iob_adr[7:0] == 8'h00);
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == 9'd0);
  assign w_push_ok = w_push & ~w_full;
  assign w_pop     = w_pop_req & w_pop_en & ~w_empty;
  assign w_done    = r_m_val & m_rdy;
  assign w_unused  = &{1'b0, iob_adr[31:8], iob_wdat[31:8], m_rdat[31:1]};

`ifdef UART_TXFIFO_FLUSH_EN
  logic r_nopop;

  assign w_flush  = w_cpu_wr & (iob_adr[7:0] == 8'h08) & iob_wdat[1];
  assign w_pop_en = ~w_flush & ~r_nopop;

  // A send already under way when the FIFO is flushed must not pop on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nopop <= 1'b0;
    end else if (w_flush && (r_state == S_SEND) && !w_done) begin
      r_nopop <= 1'b1;
    end else if (w_done && (r_state == S_SEND)) begin
      r_nopop <= 1'b0;
    end
  end
`else
  assign w_flush  = 1'b0;
  assign w_pop_en = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iob_rdy  <= 1'b0;
      r_drain_en <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_iob_rdy <= iob_val & ~r_iob_rdy;
      if (w_cpu_wr && (iob_adr[7:0] == 8'h08)) begin
        r_drain_en <= iob_wdat[0];
      end
      if (w_push && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_cpu_wr && (iob_adr[7:0] == 8'h04) && iob_wdat[2]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= 9'd0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= 9'd0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + 9'd1;
      end else if (!w_push_ok && w_pop) begin
        r_count <= r_count - 9'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= iob_wdat[7:0];
  end

  always_comb begin
    iob_rdat = 32'h0;
    case (iob_adr[7:0])
      8'h04:   iob_rdat = {15'h0, r_count, 5'h0, r_ovf, w_full, w_empty};
      8'h08:   iob_rdat = {31'h0, r_drain_en};
      default: iob_rdat = 32'h0;
    endcase
  end

  // Issue only while m_val is low, so each completion leaves at least one idle cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_m_val_nxt  = r_m_val;
    w_m_adr_nxt  = r_m_adr;
    w_m_wen_nxt  = r_m_wen;
    w_m_wdat_nxt = r_m_wdat;
    w_pop_req    = 1'b0;
    if (w_done) begin
      w_m_val_nxt = 1'b0;
      w_m_wen_nxt = 4'h0;
    end
    case (r_state)
      S_INIT: begin
        if (w_done) begin
          w_state_nxt = S_IDLE;
        end else if (!r_m_val) begin
          w_m_val_nxt  = 1'b1;
          w_m_adr_nxt  = UART_BASE;
          w_m_wen_nxt  = 4'hF;
          w_m_wdat_nxt = 32'h1;
        end
      end
      S_IDLE: begin
        if (r_drain_en && !w_empty) w_state_nxt = S_POLL;
      end
      S_POLL: begin
        if (w_done) begin
          if (!r_drain_en || w_empty) w_state_nxt = S_IDLE;
          else if (m_rdat[0])         w_state_nxt = S_POLL;
          else                        w_state_nxt = S_SEND;
        end else if (!r_m_val) begin
          w_m_val_nxt  = 1'b1;
          w_m_adr_nxt  = UART_BASE + 32'h4;
          w_m_wen_nxt  = 4'h0;
          w_m_wdat_nxt = 32'h0;
        end
      end
      S_SEND: begin
        if (w_done) begin
          w_pop_req   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!r_m_val) begin
          w_m_val_nxt  = 1'b1;
          w_m_adr_nxt  = UART_BASE + 32'hC;
          w_m_wen_nxt  = 4'hF;
          w_m_wdat_nxt = {24'h0, r_mem[r_rptr]};
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_INIT;
      r_m_val  <= 1'b0;
      r_m_adr  <= 32'h0;
      r_m_wen  <= 4'h0;
      r_m_wdat <= 32'h0;
    end else begin
      r_state  <= w_state_nxt;
      r_m_val  <= w_m_val_nxt;
      r_m_adr  <= w_m_adr_nxt;
      r_m_wen  <= w_m_wen_nxt;
      r_m_wdat <= w_m_wdat_nxt;
    end
  end

  assign iob_rdy = r_iob_rdy;
  assign m_val   = r_m_val;
  assign m_adr   = r_m_adr;
  assign m_wen   = r_m_wen;
  assign m_wdat  = r_m_wdat;

endmodule
`default_nettype wire

// File: doc/uart_txfifo.md
UART_TXFIFO -- requirements
Module: uart_txfifo

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
DEPTH  16  FIFO entries, power of two, 4..256
UART_BASE  32'h0  base address of the downstream uart, added to every m_adr
REQ-002 Ports (name  direction  width  meaning) SHALL be:
clk  in  1  single clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low
iob_val  in  1  CPU-side request valid
iob_rdy  out  1  CPU-side ready; iob_val registered one cycle
iob_adr  in  32  CPU-side address; bits[7:0] decoded
iob_wen  in  4  CPU-side byte write enables; any bit set = write
iob_wdat  in  32  CPU-side write data
iob_rdat  out  32  CPU-side read data, combinational on iob_adr[7:0]
m_val  out  1  uart-side request valid
m_rdy  in  1  uart-side ready
m_adr  out  32  uart-side address
m_wen  out  4  uart-side write enables
m_wdat  out  32  uart-side write data
m_rdat  in  32  uart-side read data

Function
REQ-003 CPU write SHALL take effect in the cycle (|iob_wen) & ~iob_rdy; reads SHALL return 0 for undecoded offsets.
REQ-004 CPU map SHALL be: 0x00 DATA (wo, push iob_wdat[7:0]); 0x04 STATUS (bit0 empty, bit1 full, bit2 overflow, bits[16:8] count); 0x08 CTRL (rw, bit0 drain_en).
REQ-005 STATUS bit2 SHALL be sticky, set by a push while full, cleared by a STATUS write with wdat[2]=1; other STATUS bits SHALL be read-only.
REQ-006 Push while full SHALL drop the byte even if a pop occurs in the same cycle; push and pop together when not full SHALL leave count unchanged.
REQ-007 Read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-008 Master FSM states SHALL be S_INIT, S_IDLE, S_POLL, S_SEND.
REQ-009 S_INIT SHALL issue one write of 32'h1 to UART_BASE+0x00 (uart tx enable), then go to S_IDLE.
REQ-010 S_IDLE SHALL go to S_POLL when drain_en=1 and FIFO not empty; otherwise stay.
REQ-011 S_POLL SHALL read UART_BASE+0x04; on completion, m_rdat[0]=0 -> S_SEND, m_rdat[0]=1 -> repeat S_POLL.
REQ-012 S_SEND SHALL write {24'h0, head byte} to UART_BASE+0x0C with m_wen=4'hF; on completion the head SHALL be popped and FSM SHALL go to S_IDLE.
REQ-013 A transaction SHALL complete at the edge where m_val=1 and m_rdy=1; m_val SHALL drop at that edge and stay low for at least one full cycle before the next assertion.
REQ-014 m_wen SHALL be 4'h0 whenever m_val=0 or the transaction is a read; m_adr/m_wdat SHALL stay stable while m_val=1.
REQ-015 m_rdat SHALL be sampled only at the completion edge.
REQ-016 Clearing drain_en SHALL not abort an in-flight transaction; FSM SHALL return to S_IDLE after it completes.

Reset
REQ-017 On rst=0, asynchronously: iob_rdy=0, m_val=0, m_wen=0, m_adr=0, m_wdat=0, pointers=0, count=0, overflow=0, drain_en=0, FSM=S_INIT.
REQ-018 Reset mid-transaction SHALL discard FIFO contents and the in-flight transaction; S_INIT SHALL re-run after release.

Configuration
REQ-019 With UART_TXFIFO_FLUSH_EN defined, a CTRL write with wdat[1]=1 SHALL empty the FIFO in that cycle (pointers=0, count=0, overflow unchanged), an in-flight S_SEND SHALL finish without popping, and CTRL bit1 SHALL read 0.
REQ-020 Without UART_TXFIFO_FLUSH_EN, CTRL bit1 SHALL be ignored and read 0.

Verification
REQ-021 Release reset, model uart with rdy=registered val -> exactly one write of 32'h1 to 0x00, then m_val idle.
REQ-022 Push 0x41,0x42,0x43, set CTRL=1, uart status busy=0 -> writes 0x41,0x42,0x43 to 0x0C in order, STATUS reads 0x1 (empty) at end.
REQ-023 Uart status busy=1 for 3 polls then 0 -> 4 reads of 0x04, then one write to 0x0C, no write while busy.
REQ-024 drain_en=0, push 17 bytes into DEPTH=16 -> STATUS=0x0000_1006 (count 16, full, overflow); write STATUS 0x4 -> overflow clears.
REQ-025 Check gap: between any two completions m_val=0 for >=1 cycle and m_wen=0 whenever m_val=0.
REQ-026 With UART_TXFIFO_FLUSH_EN, push 5 bytes, drain_en=0, write CTRL=0x2 -> STATUS=0x1 next cycle, no uart write follows.
